// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite master: bus widths, response codes and FSM states.
package axi_lite_pkg;

    localparam int AXI_ADDR_W = 4;
    localparam int AXI_DATA_W = 32;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_AW_W,
        S_WR_B,
        S_RD_AR,
        S_RD_R
    } state_e;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns one local command into an AW/W/B or AR/R
// transaction and reports the result on a one-cycle response strobe. All outputs are registered.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              busy,
    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic              RVALID,
    output logic              RREADY,
    input  logic [1:0]        RRESP
);

    state_e state, state_nxt;
    logic   aw_done, w_done;
    logic   aw_done_d, w_done_d;

    logic              cmd_ready_d, busy_d, rsp_valid_d, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_d, wdata_d;
    logic [1:0]        rsp_resp_d;
    logic [ADDR_W-1:0] awaddr_d, araddr_d;
    logic              awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;

    logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign accept = cmd_valid & cmd_ready;
    assign aw_hs  = AWVALID & AWREADY;
    assign w_hs   = WVALID & WREADY;
    assign b_hs   = BVALID & BREADY;
    assign ar_hs  = ARVALID & ARREADY;
    assign r_hs   = RVALID & RREADY;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = cmd_write ? S_WR_AW_W : S_RD_AR;
            S_WR_AW_W: if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = S_WR_B;
            S_WR_B:    if (b_hs) state_nxt = S_IDLE;
            S_RD_AR:   if (ar_hs) state_nxt = S_RD_R;
            S_RD_R:    if (r_hs) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_d = cmd_ready;
        busy_d      = busy;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write;
        rsp_rdata_d = rsp_rdata;
        rsp_resp_d  = rsp_resp;
        awaddr_d    = AWADDR;
        wdata_d     = WDATA;
        araddr_d    = ARADDR;
        awvalid_d   = AWVALID;
        wvalid_d    = WVALID;
        bready_d    = BREADY;
        arvalid_d   = ARVALID;
        rready_d    = RREADY;
        aw_done_d   = aw_done;
        w_done_d    = w_done;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR_AW_W: begin
                // AW and W complete independently; each VALID drops right after its own handshake.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                end
            end
            S_WR_B: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = BRESP;
                end
            end
            S_RD_AR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_RD_R: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = RDATA;
                    rsp_resp_d  = RRESP;
                end
            end
            default: ;
        endcase

        // The FSM is already back in IDLE during the pulse; new commands wait one more cycle.
        if (rsp_valid) begin
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
            AWADDR    <= '0;
            WDATA     <= '0;
            ARADDR    <= '0;
            AWVALID   <= 1'b0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            cmd_ready <= cmd_ready_d;
            busy      <= busy_d;
            rsp_valid <= rsp_valid_d;
            rsp_write <= rsp_write_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_resp  <= rsp_resp_d;
            AWADDR    <= awaddr_d;
            WDATA     <= wdata_d;
            ARADDR    <= araddr_d;
            AWVALID   <= awvalid_d;
            WVALID    <= wvalid_d;
            BREADY    <= bready_d;
            ARVALID   <= arvalid_d;
            RREADY    <= rready_d;
            aw_done   <= aw_done_d;
            w_done    <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: a delay-configurable 4-register slave, a cycle monitor,
// and one task per scenario with hand-computed expected values.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int AW = AXI_ADDR_W;
    localparam int DW = AXI_DATA_W;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid, rsp_write, busy;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [DW-1:0] WDATA;
    logic          AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic          AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
    logic [1:0]    BRESP = 2'b00, RRESP = 2'b00;
    logic [DW-1:0] RDATA = '0;

    axi_lite_master dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .busy(busy),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Slave configuration (written only by the test sequence)
    int       aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;

    // Slave state
    logic [DW-1:0] mem [4];
    int            aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic          aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0;
    logic [AW-1:0] aw_addr_c = '0, ar_addr_c = '0;
    logic [DW-1:0] w_data_c = '0;
    int            aw_hs_cyc = -1, w_hs_cyc = -1;

    initial for (int i = 0; i < 4; i++) mem[i] = '0;

    // Slave drives on the falling edge; a READY/VALID set here meets a DUT output that is
    // stable until the next rising edge, so the handshake is known at decision time.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
        end else begin
            if (b_fire) begin
                BVALID = 0; b_fire = 0;
            end else if (BVALID) begin
                if (BREADY) b_fire = 1;
            end else if (aw_got && w_got) begin
                if (b_cnt >= b_dly) begin
                    mem[aw_addr_c[3:2]] = w_data_c;
                    BVALID = 1; BRESP = b_resp_cfg;
                    aw_got = 0; w_got = 0; b_cnt = 0;
                    if (BREADY) b_fire = 1;
                end else b_cnt++;
            end
            if (AWVALID && !aw_got) begin
                if (aw_cnt >= aw_dly) begin
                    AWREADY = 1; aw_got = 1; aw_addr_c = AWADDR; aw_hs_cyc = cyc;
                end else begin
                    AWREADY = 0; aw_cnt++;
                end
            end else begin
                AWREADY = 0; aw_cnt = 0;
            end
            if (WVALID && !w_got) begin
                if (w_cnt >= w_dly) begin
                    WREADY = 1; w_got = 1; w_data_c = WDATA; w_hs_cyc = cyc;
                end else begin
                    WREADY = 0; w_cnt++;
                end
            end else begin
                WREADY = 0; w_cnt = 0;
            end
            if (r_fire) begin
                RVALID = 0; r_fire = 0;
            end else if (RVALID) begin
                if (RREADY) r_fire = 1;
            end else if (ar_got) begin
                if (r_cnt >= r_dly) begin
                    RVALID = 1; RDATA = mem[ar_addr_c[3:2]]; RRESP = r_resp_cfg;
                    ar_got = 0; r_cnt = 0;
                    if (RREADY) r_fire = 1;
                end else r_cnt++;
            end
            if (ARVALID && !ar_got) begin
                if (ar_cnt >= ar_dly) begin
                    ARREADY = 1; ar_got = 1; ar_addr_c = ARADDR;
                end else begin
                    ARREADY = 0; ar_cnt++;
                end
            end else begin
                ARREADY = 0; ar_cnt = 0;
            end
        end
    end

    // Cycle monitor
    int            rsp_count = 0, last_rsp_cyc = -1;
    logic          last_rsp_write = 0;
    logic [DW-1:0] last_rsp_rdata = '0;
    logic [1:0]    last_rsp_resp = '0;
    int            awv_cnt = 0, wv_cnt = 0, rready_cnt = 0, busy_cnt = 0;
    int            bready_early = 0, unstable = 0;
    logic          prev_awvalid = 0, prev_wvalid = 0;
    logic [AW-1:0] prev_awaddr = '0;
    logic [DW-1:0] prev_wdata = '0;

    always @(negedge ACLK) begin
        if (rsp_valid) begin
            rsp_count++;
            last_rsp_cyc   = cyc;
            last_rsp_write = rsp_write;
            last_rsp_rdata = rsp_rdata;
            last_rsp_resp  = rsp_resp;
        end
        if (AWVALID) awv_cnt++;
        if (WVALID) wv_cnt++;
        if (RREADY) rready_cnt++;
        if (busy) busy_cnt++;
        if (BREADY && (AWVALID || WVALID)) bready_early++;
        if (AWVALID && prev_awvalid && AWADDR !== prev_awaddr) unstable++;
        if (WVALID && prev_wvalid && WDATA !== prev_wdata) unstable++;
        prev_awvalid = AWVALID; prev_awaddr = AWADDR;
        prev_wvalid  = WVALID;  prev_wdata  = WDATA;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ACLK);
            #1;
        end
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int acc);
        int n;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        n = 0; acc = -1;
        while (!cmd_ready && n < 50) begin
            step(1); n++;
        end
        if (cmd_ready) acc = cyc;
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready never rose within 50 cycles (expected acceptance)");
        end
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_count < target && n < 60) begin
            step(1); n++;
        end
        checks++;
        if (rsp_count < target) begin
            errors++;
            $display("FAIL rsp_timeout: rsp_count=%0d expected %0d within 60 cycles", rsp_count, target);
        end
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        step(2);
        ARESETn = 1'b1;
        step(1);
        checks++;
        if ({cmd_ready, busy, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 10000000",
                     {cmd_ready, busy, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY});
        end
        checks++;
        if (AWADDR !== '0 || WDATA !== '0 || ARADDR !== '0 || rsp_rdata !== '0
            || rsp_resp !== 2'b00 || rsp_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: AWADDR=%h WDATA=%h ARADDR=%h rdata=%h resp=%b wr=%b expected all 0",
                     AWADDR, WDATA, ARADDR, rsp_rdata, rsp_resp, rsp_write);
        end
    endtask

    task automatic test_write_basic();
        int t, r0, a0, w0, b0;
        aw_dly = 0; w_dly = 0; b_dly = 0; b_resp_cfg = RESP_OKAY;
        r0 = rsp_count; a0 = awv_cnt; w0 = wv_cnt; b0 = busy_cnt;
        issue(1'b1, 4'h4, 32'hDEADBEEF, t);
        wait_rsp(r0 + 1);
        step(3);
        checks++;
        if (aw_hs_cyc != t + 1 || w_hs_cyc != t + 1) begin
            errors++;
            $display("FAIL wr_basic_hs: aw_hs=%0d w_hs=%0d expected both %0d", aw_hs_cyc, w_hs_cyc, t + 1);
        end
        checks++;
        if (aw_addr_c !== 4'h4 || w_data_c !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_basic_payload: addr=%h data=%h expected 4 DEADBEEF", aw_addr_c, w_data_c);
        end
        checks++;
        if (last_rsp_cyc != t + 3 || rsp_count != r0 + 1) begin
            errors++;
            $display("FAIL wr_basic_rsp: cycle=%0d count=%0d expected cycle %0d count %0d",
                     last_rsp_cyc, rsp_count - r0, t + 3, 1);
        end
        checks++;
        if (last_rsp_write !== 1'b1 || last_rsp_resp !== 2'b00 || last_rsp_rdata !== '0) begin
            errors++;
            $display("FAIL wr_basic_fields: wr=%b resp=%b rdata=%h expected 1 00 0",
                     last_rsp_write, last_rsp_resp, last_rsp_rdata);
        end
        checks++;
        if (awv_cnt - a0 != 1 || wv_cnt - w0 != 1 || busy_cnt - b0 != 3) begin
            errors++;
            $display("FAIL wr_basic_cycles: awvalid=%0d wvalid=%0d busy=%0d expected 1 1 3",
                     awv_cnt - a0, wv_cnt - w0, busy_cnt - b0);
        end
    endtask

    task automatic test_write_aw_delay();
        int t, r0, a0, w0, u0, e0;
        aw_dly = 3; w_dly = 0; b_resp_cfg = RESP_DECERR;
        r0 = rsp_count; a0 = awv_cnt; w0 = wv_cnt; u0 = unstable; e0 = bready_early;
        issue(1'b1, 4'hC, 32'hCAFEF00D, t);
        wait_rsp(r0 + 1);
        step(3);
        checks++;
        if (wv_cnt - w0 != 1 || awv_cnt - a0 != 4) begin
            errors++;
            $display("FAIL wr_delay_valid: wvalid=%0d awvalid=%0d expected 1 4", wv_cnt - w0, awv_cnt - a0);
        end
        checks++;
        if (unstable != u0 || bready_early != e0) begin
            errors++;
            $display("FAIL wr_delay_protocol: unstable=%0d bready_early=%0d expected 0 0",
                     unstable - u0, bready_early - e0);
        end
        checks++;
        if (last_rsp_cyc != t + 6 || rsp_count != r0 + 1 || last_rsp_resp !== 2'b11) begin
            errors++;
            $display("FAIL wr_delay_rsp: cycle=%0d count=%0d resp=%b expected %0d 1 11",
                     last_rsp_cyc, rsp_count - r0, last_rsp_resp, t + 6);
        end
        checks++;
        if (mem[3] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL wr_delay_mem: mem[3]=%h expected CAFEF00D", mem[3]);
        end
        aw_dly = 0; b_resp_cfg = RESP_OKAY;
    endtask

    task automatic test_write_read();
        int t, r0;
        r0 = rsp_count;
        issue(1'b1, 4'h8, 32'h12345678, t);
        wait_rsp(r0 + 1);
        issue(1'b0, 4'h8, 32'h0, t);
        wait_rsp(r0 + 2);
        checks++;
        if (last_rsp_rdata !== 32'h12345678 || last_rsp_resp !== 2'b00 || last_rsp_write !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_data: rdata=%h resp=%b wr=%b expected 12345678 00 0",
                     last_rsp_rdata, last_rsp_resp, last_rsp_write);
        end
        checks++;
        if (last_rsp_cyc != t + 3) begin
            errors++;
            $display("FAIL wr_rd_latency: rsp cycle=%0d expected %0d", last_rsp_cyc, t + 3);
        end
    endtask

    task automatic test_read_delay();
        int t, r0, q0, b0;
        r_dly = 5; r_resp_cfg = RESP_SLVERR;
        r0 = rsp_count; q0 = rready_cnt; b0 = busy_cnt;
        issue(1'b0, 4'h4, 32'h0, t);
        wait_rsp(r0 + 1);
        step(2);
        checks++;
        if (rready_cnt - q0 != 6 || busy_cnt - b0 != 8) begin
            errors++;
            $display("FAIL rd_delay_cycles: rready=%0d busy=%0d expected 6 8", rready_cnt - q0, busy_cnt - b0);
        end
        checks++;
        if (last_rsp_resp !== 2'b10 || last_rsp_rdata !== 32'hDEADBEEF || last_rsp_cyc != t + 8) begin
            errors++;
            $display("FAIL rd_delay_rsp: resp=%b rdata=%h cycle=%0d expected 10 DEADBEEF %0d",
                     last_rsp_resp, last_rsp_rdata, last_rsp_cyc, t + 8);
        end
        r_dly = 0; r_resp_cfg = RESP_OKAY;
    endtask

    task automatic test_back_to_back();
        int acc [2];
        int acc_n, n, r0, ready_busy;
        r0 = rsp_count; acc_n = 0; n = 0; ready_busy = 0;
        acc[0] = -1; acc[1] = -1;
        cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'h11111111; cmd_valid = 1'b1;
        while (acc_n < 2 && n < 40) begin
            if (cmd_ready && busy) ready_busy++;
            if (cmd_ready) begin
                acc[acc_n] = cyc;
                acc_n++;
            end
            step(1); n++;
            if (acc_n == 1) begin
                cmd_write = 1'b0; cmd_wdata = '0;
            end
        end
        cmd_valid = 1'b0;
        wait_rsp(r0 + 2);
        step(4);
        checks++;
        if (acc_n != 2 || acc[1] != acc[0] + 4 || ready_busy != 0) begin
            errors++;
            $display("FAIL b2b_accept: accepts=%0d gap=%0d ready_while_busy=%0d expected 2 4 0",
                     acc_n, acc[1] - acc[0], ready_busy);
        end
        checks++;
        if (rsp_count != r0 + 2 || last_rsp_cyc != acc[1] + 3) begin
            errors++;
            $display("FAIL b2b_rsp: count=%0d cycle=%0d expected 2 %0d", rsp_count - r0, last_rsp_cyc, acc[1] + 3);
        end
        checks++;
        if (last_rsp_rdata !== 32'h11111111 || last_rsp_write !== 1'b0) begin
            errors++;
            $display("FAIL b2b_data: rdata=%h wr=%b expected 11111111 0", last_rsp_rdata, last_rsp_write);
        end
    endtask

    task automatic test_reset_midflight();
        int t, r0;
        aw_dly = 20; w_dly = 20;
        r0 = rsp_count;
        issue(1'b1, 4'h4, 32'h0BADF00D, t);
        checks++;
        if ({AWVALID, WVALID} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_pre: AWVALID/WVALID=%b expected 11", {AWVALID, WVALID});
        end
        step(1);
        #2;
        ARESETn = 1'b0;
        #1;
        checks++;
        if ({AWVALID, WVALID, busy, cmd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_async: AWVALID,WVALID,busy,cmd_ready=%b expected 0001",
                     {AWVALID, WVALID, busy, cmd_ready});
        end
        step(2);
        ARESETn = 1'b1;
        aw_dly = 0; w_dly = 0;
        step(3);
        checks++;
        if (rsp_count != r0) begin
            errors++;
            $display("FAIL midrst_norsp: responses=%0d expected 0", rsp_count - r0);
        end
        issue(1'b1, 4'h0, 32'h5A5A5A5A, t);
        wait_rsp(r0 + 1);
        step(2);
        checks++;
        if (last_rsp_cyc != t + 3 || last_rsp_resp !== 2'b00 || mem[0] !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL midrst_after: cycle=%0d resp=%b mem0=%h expected %0d 00 5A5A5A5A",
                     last_rsp_cyc, last_rsp_resp, mem[0], t + 3);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_aw_delay();
        test_write_read();
        test_read_delay();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- AXI4-Lite initiator that turns single-beat commands from local logic into AW/W/B or AR/R transactions.
- Pairs with the existing 4-register AXI4-Lite slave: 4-bit byte address, 32-bit data.
- Exactly one transaction outstanding at a time; the result returns on a one-cycle response strobe.
- Sits between CPU-side or testbench control logic and the AXI4-Lite interconnect.

Parameters:
- ADDR_W, 4, AXI address width (byte address).
- DATA_W, 32, AXI data width. Only 32 is supported.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transaction address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse: transaction complete.
- rsp_write  out  1  echoes cmd_write of the completed transaction.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP captured from the slave.
- busy  out  1  high from command acceptance until the cycle rsp_valid pulses.
- AWADDR out ADDR_W, AWVALID out 1, AWREADY in 1: write-address channel.
- WDATA out DATA_W, WVALID out 1, WREADY in 1: write-data channel.
- BRESP in 2, BVALID in 1, BREADY out 1: write-response channel.
- ARADDR out ADDR_W, ARVALID out 1, ARREADY in 1: read-address channel.
- RDATA in DATA_W, RVALID in 1, RREADY out 1, RRESP in 2: read-data channel.

Behaviour:
- Reset (asynchronous, immediate):
  - All VALID/READY outputs, rsp_valid and busy go to 0; cmd_ready goes to 1.
  - AWADDR, WDATA, ARADDR, rsp_rdata, rsp_resp, rsp_write go to 0.
  - State goes to IDLE. An in-flight transaction is abandoned with no rsp_valid.
- Registered outputs: every AXI output and every rsp_* output comes from a flop.
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R.
- IDLE:
  - cmd_ready = 1.
  - On acceptance, latch cmd_addr and cmd_wdata into AWADDR/WDATA (write) or ARADDR (read).
  - Go to WR_AW_W or RD_AR; AWVALID and WVALID (or ARVALID) rise on the next cycle.
- WR_AW_W:
  - AWVALID and WVALID are asserted together and complete independently.
  - Internal flags aw_done and w_done are set on their respective handshakes.
  - A VALID drops the cycle after its handshake and never drops before it.
  - Once both are done, clear the flags and go to WR_B. Handshakes may land in the same cycle or in either order.
- WR_B:
  - BREADY = 1.
  - On BVALID, capture BRESP into rsp_resp, set rsp_rdata = 0, pulse rsp_valid the next cycle, return to IDLE.
- RD_AR: ARVALID held until ARREADY, then go to RD_R.
- RD_R:
  - RREADY = 1.
  - On RVALID, capture RDATA and RRESP, pulse rsp_valid the next cycle, return to IDLE.
- Latency with slave readies already high:
  - Write: accept at T, AW/W handshakes at T+1, B handshake at T+2 at the earliest, rsp_valid at T+3.
  - Read: accept at T, AR handshake at T+1, R handshake at T+2 at the earliest, rsp_valid at T+3.
- Protocol rules:
  - VALID never depends combinationally on READY.
  - Address and data stay stable while VALID is high and READY is low.
- Boundary conditions:
  - cmd_valid while busy: ignored; cmd_ready = 0.
  - A response that is not OKAY (SLVERR/DECERR) is passed through unchanged; it is not an internal error.
  - An unsolicited BVALID/RVALID outside WR_B/RD_R: BREADY/RREADY stay 0 and nothing is captured.
- No timeout. A hung slave leaves busy = 1 until reset.

Decomposition:
- Package axi_lite_pkg, holding:
  - ADDR_W/DATA_W constants.
  - Response enum: RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - Master state enum.
- One module, no sub-module. The FSM plus the aw_done/w_done flags fit comfortably in one file.

Test Plan:
- Write cmd_addr = 4'h4, cmd_wdata = 32'hDEADBEEF, slave readies immediate -> AWADDR = 4'h4 and WDATA = DEADBEEF handshake in the same cycle; rsp_valid pulses once at T+3 with rsp_write = 1, rsp_resp = 00.
- Write with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles with AWADDR stable, BREADY only after both handshakes, a single rsp_valid.
- Write 32'h12345678 to 4'h8, then read 4'h8 -> read rsp_rdata = 32'h12345678, rsp_resp = 00, rsp_write = 0.
- Read with RVALID delayed 5 cycles and RRESP = 2'b10 -> RREADY held high throughout, rsp_resp = 10, busy high until the pulse.
- cmd_valid held high while busy -> cmd_ready = 0 and the second command is accepted only in the cycle after rsp_valid; exactly two responses in total.
- ARESETn asserted between clock edges while AWVALID = 1 -> AWVALID/WVALID drop immediately, no rsp_valid; the next write after reset completes normally.
